// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and 32-entry architectural register file.
//
// Consumes the MEM/WB pipeline register outputs, selects the write-back
// value, and retires it into the GPR array. The ID stage reads through two
// combinational ports. A third combinational port serves debug. A saturating
// counter tracks retired register writes for bring-up.
//
// Parameters:
//   DATA_W - register/data width
//   ADDR_W - register index width (depth = 2**ADDR_W)
//   CNT_W  - retired-write counter width
//
// Ports:
//   clk, rst              - clock; synchronous active-high reset
//   memory_in, result_in  - load data / ALU result from MEM/WB
//   Rw_in                 - destination register index
//   MemtoReg_in           - 1 selects memory_in, 0 selects result_in
//   RegWr_in              - write enable from MEM/WB
//   ra_addr/ra_data       - read port A (combinational)
//   rb_addr/rb_data       - read port B (combinational)
//   wb_data               - selected write-back value (combinational)
//   dbg_addr/dbg_data     - debug read port (combinational, never bypassed)
//   wb_count              - saturating count of retired register writes
//
// Build option:
//   WB_BYPASS_EN - when defined, ra_data/rb_data forward wb_data in the
//                  cycle their index matches a valid write target.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] memory_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [ADDR_W-1:0] Rw_in,
  input  logic              MemtoReg_in,
  input  logic              RegWr_in,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wb_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_valid;

  assign wb_data  = MemtoReg_in ? memory_in : result_in;
  assign wr_valid = RegWr_in && (Rw_in != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_valid) begin
      regs[Rw_in] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_count <= '0;
    end else if (wr_valid && (wb_count != '1)) begin
      wb_count <= wb_count + CNT_ONE;
    end
  end

  // Index 0 is forced to zero on every port rather than relying on the
  // stored entry, so r0 reads 0 even before the first reset.
  always_comb begin
    ra_data  = (ra_addr == '0)  ? '0 : regs[ra_addr];
    rb_data  = (rb_addr == '0)  ? '0 : regs[rb_addr];
    dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
`ifdef WB_BYPASS_EN
    if (wr_valid && (ra_addr == Rw_in)) ra_data = wb_data;
    if (wr_valid && (rb_addr == Rw_in)) rb_data = wb_data;
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 3;
  localparam int NREG   = 32;
  localparam int CMAX   = 7;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] memory_in;
  logic [DATA_W-1:0] result_in;
  logic [ADDR_W-1:0] Rw_in;
  logic              MemtoReg_in;
  logic              RegWr_in;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [CNT_W-1:0]  wb_count;

  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .memory_in(memory_in), .result_in(result_in),
    .Rw_in(Rw_in), .MemtoReg_in(MemtoReg_in), .RegWr_in(RegWr_in),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
    .wb_data(wb_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wb_count(wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain array of architectural values plus a retired count.
  int unsigned model_regs [NREG];
  int          model_cnt;
  bit          model_valid = 0;

  function automatic int unsigned sel_value();
    return MemtoReg_in ? memory_in : result_in;
  endfunction

  function automatic int unsigned expect_read(input int idx, input bit bypass_ok);
    if (idx == 0) return 0;
`ifdef WB_BYPASS_EN
    if (bypass_ok && RegWr_in && Rw_in != 0 && idx == int'(Rw_in)) return sel_value();
`endif
    return model_regs[idx];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      foreach (model_regs[i]) model_regs[i] = 0;
      model_cnt   = 0;
      model_valid = 1;
    end else if (RegWr_in && Rw_in != 0) begin
      model_regs[Rw_in] = sel_value();
      if (model_cnt < CMAX) model_cnt++;
    end
  end

  always @(negedge clk) begin
    check("wb_data", wb_data, sel_value());
    if (model_valid) begin
      check("ra_data", ra_data, expect_read(int'(ra_addr), 1'b1));
      check("rb_data", rb_data, expect_read(int'(rb_addr), 1'b1));
      check("dbg_data", dbg_data, expect_read(int'(dbg_addr), 1'b0));
      check("wb_count", 32'(wb_count), 32'(model_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    RegWr_in = 1'b0;
    rst      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; memory_in = '0; result_in = '0; Rw_in = '0; MemtoReg_in = 1'b0;
    RegWr_in = 1'b0; ra_addr = '0; rb_addr = '0; dbg_addr = '0;
    tick(); tick();
    idle();

    // Reset clear with preloaded r5
    RegWr_in = 1'b1; Rw_in = 5'd5; result_in = 32'h1234_5678; MemtoReg_in = 1'b0;
    tick();
    RegWr_in = 1'b0; ra_addr = 5'd5;
    settle();
    check("preload_r5", ra_data, 32'h1234_5678);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("reset_r5", ra_data, 32'h0);
    check("reset_count", 32'(wb_count), 32'h0);
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = i[ADDR_W-1:0];
      #1;
      check("reset_dbg", dbg_data, 32'h0);
    end
    tick();

    // Mux and write, result path
    result_in = 32'hA5A5_A5A5; memory_in = 32'h5A5A_5A5A; MemtoReg_in = 1'b0;
    RegWr_in = 1'b1; Rw_in = 5'd3;
    settle();
    check("mux_result", wb_data, 32'hA5A5_A5A5);
    tick();
    RegWr_in = 1'b0; rb_addr = 5'd3;
    settle();
    check("write_r3", rb_data, 32'hA5A5_A5A5);
    check("count_1", 32'(wb_count), 32'd1);
    tick();

    // Mux and write, memory path
    MemtoReg_in = 1'b1; RegWr_in = 1'b1; Rw_in = 5'd4;
    settle();
    check("mux_memory", wb_data, 32'h5A5A_5A5A);
    tick();
    RegWr_in = 1'b0; ra_addr = 5'd4;
    settle();
    check("write_r4", ra_data, 32'h5A5A_5A5A);
    check("count_2", 32'(wb_count), 32'd2);
    tick();

    // r0 protection
    MemtoReg_in = 1'b0; result_in = 32'hFFFF_FFFF; RegWr_in = 1'b1; Rw_in = 5'd0;
    tick();
    RegWr_in = 1'b0; ra_addr = 5'd0; dbg_addr = 5'd0;
    settle();
    check("r0_read", ra_data, 32'h0);
    check("r0_dbg", dbg_data, 32'h0);
    check("r0_count", 32'(wb_count), 32'd2);
    tick();

    // Same-cycle hazard on r7
    result_in = 32'h11; RegWr_in = 1'b1; Rw_in = 5'd7;
    tick();
    result_in = 32'h0000_0BEE; ra_addr = 5'd7; rb_addr = 5'd7; dbg_addr = 5'd7;
    settle();
`ifdef WB_BYPASS_EN
    check("hazard_ra", ra_data, 32'h0000_0BEE);
    check("hazard_rb", rb_data, 32'h0000_0BEE);
`else
    check("hazard_ra", ra_data, 32'h11);
    check("hazard_rb", rb_data, 32'h11);
`endif
    check("hazard_dbg", dbg_data, 32'h11);
    tick();
    RegWr_in = 1'b0;
    settle();
    check("hazard_next_ra", ra_data, 32'h0000_0BEE);
    check("hazard_next_rb", rb_data, 32'h0000_0BEE);
    tick();

    // Reset coinciding with a write
    rst = 1'b1; RegWr_in = 1'b1; Rw_in = 5'd9; result_in = 32'h0000_DEAD;
    tick();
    idle(); dbg_addr = 5'd9;
    settle();
    check("rst_write_r9", dbg_data, 32'h0);
    check("rst_write_count", 32'(wb_count), 32'h0);
    tick();

    // Counter saturation: 10 writes, count 1..7 then holds
    for (int i = 1; i <= 10; i++) begin
      RegWr_in = 1'b1; Rw_in = 5'(i + 10); result_in = 32'(i * 3);
      tick();
      RegWr_in = 1'b0;
      settle();
      check("sat_count", 32'(wb_count), 32'((i < 7) ? i : 7));
    end
    tick();

    // Randomized traffic checked against the model every cycle
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 49) == 0);
      RegWr_in    = ($urandom_range(0, 3) != 0);
      Rw_in       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      MemtoReg_in = 1'($urandom);
      memory_in   = $urandom;
      result_in   = $urandom;
      ra_addr     = ($urandom_range(0, 3) == 0) ? Rw_in : 5'($urandom);
      rb_addr     = ($urandom_range(0, 3) == 0) ? Rw_in : 5'($urandom);
      dbg_addr    = ($urandom_range(0, 3) == 0) ? Rw_in : 5'($urandom);
      tick();
    end
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
